top_entity: RTL and testbench

- Hardware stream monitor with one 64-bit signed input stream and four event-driven output streams.
- The outputs form a dependency chain: out0 = in0+1, out1 = out0+1, out2 = out1+1, out3 = out2+1.
- Input events enter an event queue and are evaluated by a tight pipeline, one stage per output, with successive events overlapping.
- Sits between an input sampler (new-value strobe) and a verdict/trace sink.

---
 rtl/top_entity_if.sv | 30 +++
 rtl/top_entity.sv | 118 +++++++++++
 tb/tb_top_entity.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/top_entity_if.sv
// Stream bundle between the input sampler / verdict sink and the monitor.
//   input_0, new_input_0          : sampled input value and its new-event strobe
//   output_k, output_k_aktv (k=0..3): computed stream values and their one-cycle fresh flags
// Modports: master = sampler/sink side, slave = monitor side.
interface top_entity_if #(
    parameter int unsigned DATA_W = 64
);
    logic signed [DATA_W-1:0] input_0;
    logic                     new_input_0;
    logic signed [DATA_W-1:0] output_0;
    logic signed [DATA_W-1:0] output_1;
    logic signed [DATA_W-1:0] output_2;
    logic signed [DATA_W-1:0] output_3;
    logic                     output_0_aktv;
    logic                     output_1_aktv;
    logic                     output_2_aktv;
    logic                     output_3_aktv;

    modport master (
        output input_0, new_input_0,
        input  output_0, output_1, output_2, output_3,
        input  output_0_aktv, output_1_aktv, output_2_aktv, output_3_aktv
    );

    modport slave (
        input  input_0, new_input_0,
        output output_0, output_1, output_2, output_3,
        output output_0_aktv, output_1_aktv, output_2_aktv, output_3_aktv
    );
endinterface

// File: rtl/top_entity.sv
// Stream monitor: input events are queued, then evaluated by a four-stage chain
// output_0 = in+1, output_k = output_(k-1)+1, one stage per cycle, events overlapping.
// Ports:
//   clk, rst (async, active-low), en (global clock enable)
//   bus          : stream bundle (slave side), see top_entity_if
//   q_push, q_pop, q_push_valid, q_pop_valid : event-queue handshake status
//   enable_in0   : input stage evaluating (pop performed this cycle)
//   enable_out0..enable_out3 : stage k evaluating this cycle
module top_entity #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned DATA_W      = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    top_entity_if.slave bus,
    output logic       q_push,
    output logic       q_pop,
    output logic       q_push_valid,
    output logic       q_pop_valid,
    output logic       enable_in0,
    output logic       enable_out0,
    output logic       enable_out1,
    output logic       enable_out2,
    output logic       enable_out3
);
    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

    logic [DATA_W-1:0]        mem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q;
    logic [PTR_W-1:0]         rd_ptr_q;
    logic [CNT_W-1:0]         count_q;
    logic                     s0_valid_q;
    logic signed [DATA_W-1:0] s0_data_q;
    logic signed [DATA_W-1:0] out_q [4];
    logic [3:0]               aktv_q;

    logic empty;
    logic full;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Full/empty come from pre-edge state, so a push into a full queue is dropped
    // even when a pop happens in the same cycle.
    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_W'(QUEUE_DEPTH));
    assign q_push       = bus.new_input_0 & en;
    assign q_pop        = ~empty & en;
    assign q_push_valid = q_push & ~full;
    assign q_pop_valid  = q_pop & ~empty;

    assign enable_in0  = q_pop_valid;
    assign enable_out0 = s0_valid_q;
    assign enable_out1 = aktv_q[0];
    assign enable_out2 = aktv_q[1];
    assign enable_out3 = aktv_q[2];

    assign bus.output_0      = out_q[0];
    assign bus.output_1      = out_q[1];
    assign bus.output_2      = out_q[2];
    assign bus.output_3      = out_q[3];
    assign bus.output_0_aktv = aktv_q[0];
    assign bus.output_1_aktv = aktv_q[1];
    assign bus.output_2_aktv = aktv_q[2];
    assign bus.output_3_aktv = aktv_q[3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            s0_valid_q <= 1'b0;
            s0_data_q  <= '0;
            for (int k = 0; k < 4; k++) begin
                out_q[k] <= '0;
            end
            aktv_q     <= '0;
        end else if (en) begin
            // Event queue; no bypass, a push into an empty queue pops next cycle.
            if (q_push_valid) begin
                mem_q[wr_ptr_q] <= bus.input_0;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (q_pop_valid) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (q_push_valid && !q_pop_valid) begin
                count_q <= count_q + 1'b1;
            end else if (!q_push_valid && q_pop_valid) begin
                count_q <= count_q - 1'b1;
            end

            // Stage S0 captures the popped event.
            s0_valid_q <= q_pop_valid;
            if (q_pop_valid) begin
                s0_data_q <= mem_q[rd_ptr_q];
            end

            // Output chain: each fresh flag is the previous stage's valid, delayed one cycle.
            aktv_q <= {aktv_q[2:0], s0_valid_q};
            if (s0_valid_q) begin
                out_q[0] <= s0_data_q + DATA_W'(1);
            end
            for (int k = 1; k < 4; k++) begin
                if (aktv_q[k-1]) begin
                    out_q[k] <= out_q[k-1] + DATA_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_top_entity.sv
// Self-checking bench for top_entity: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against an event-age model.
module tb_top_entity;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic q_push, q_pop, q_push_valid, q_pop_valid, enable_in0;
    logic enable_out0, enable_out1, enable_out2, enable_out3;

    top_entity_if #(.DATA_W(64)) bus ();

    top_entity #(.QUEUE_DEPTH(DEPTH), .DATA_W(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .bus          (bus),
        .q_push       (q_push),
        .q_pop        (q_pop),
        .q_push_valid (q_push_valid),
        .q_pop_valid  (q_pop_valid),
        .enable_in0   (enable_in0),
        .enable_out0  (enable_out0),
        .enable_out1  (enable_out1),
        .enable_out2  (enable_out2),
        .enable_out3  (enable_out3)
    );

    always #5 clk = ~clk;

    logic [3:0] aktv_v;
    logic [3:0] en_v;
    assign aktv_v = {bus.output_3_aktv, bus.output_2_aktv, bus.output_1_aktv, bus.output_0_aktv};
    assign en_v   = {enable_out3, enable_out2, enable_out1, enable_out0};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outv(input int k);
        case (k)
            0:       return bus.output_0;
            1:       return bus.output_1;
            2:       return bus.output_2;
            default: return bus.output_3;
        endcase
    endfunction

    // One cycle: drive inputs after the falling edge, settle, caller then checks.
    task automatic drive(input logic e, input logic n, input logic [63:0] d);
        @(negedge clk);
        en              = e;
        bus.new_input_0 = n;
        bus.input_0     = d;
        #1;
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        rst             = 1'b0;
        en              = 1'b1;
        bus.new_input_0 = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) chk($sformatf("%s out%0d", tag, k), outv(k), 64'd0);
        chk({tag, " aktv"}, {60'd0, aktv_v}, 64'd0);
        chk({tag, " enables"}, {59'd0, enable_in0, en_v}, 64'd0);
        chk({tag, " q_pop/q_push_valid"}, {62'd0, q_pop, q_push_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Directed vector table.
    typedef struct {
        logic             nin;
        logic [63:0]      din;
        logic             pv;
        logic             popv;
        logic [3:0]       aktv;
        logic [3:0][63:0] v;
    } vec_t;
    vec_t tbl [16];

    // Reference model: pending queue plus in-flight events tagged with their age
    // in enabled edges since the pop (age a>=2 means output_(a-2) = value + a - 1).
    logic [63:0] mq [$];
    logic [63:0] fv [$];
    int          fa [$];
    logic [63:0] m_out [4];
    logic [3:0]  m_aktv;

    function automatic void model_reset();
        mq.delete();
        fv.delete();
        fa.delete();
        m_aktv = '0;
        for (int k = 0; k < 4; k++) m_out[k] = '0;
    endfunction

    logic [63:0] o0v [$];
    logic [63:0] o3v [$];
    int          o0c [$];
    int          o3c [$];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [63:0] ev [2];
        logic [3:0][63:0] cur;
        int pushes;
        int pops;

        bus.new_input_0 = 1'b0;
        bus.input_0     = '0;

        // Reset state.
        #12;
        for (int k = 0; k < 4; k++) chk($sformatf("reset out%0d", k), outv(k), 64'd0);
        chk("reset aktv", {60'd0, aktv_v}, 64'd0);
        chk("reset enables", {59'd0, enable_in0, en_v}, 64'd0);
        chk("reset q_pop/valids", {61'd0, q_pop, q_push_valid, q_pop_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Table: single event 1, then the wrap-around case.
        ev[0] = 64'd1;
        ev[1] = 64'h7FFF_FFFF_FFFF_FFFF;
        cur   = '0;
        for (int r = 0; r < 16; r++) begin
            automatic int o = r % 8;
            tbl[r].nin  = (o == 0);
            tbl[r].din  = (o == 0) ? ev[r/8] : 64'd0;
            tbl[r].pv   = (o == 0);
            tbl[r].popv = (o == 1);
            tbl[r].aktv = '0;
            if (o >= 3 && o <= 6) begin
                tbl[r].aktv[o-3] = 1'b1;
                cur[o-3]         = ev[r/8] + 64'(o - 2);
            end
            tbl[r].v = cur;
        end
        for (int r = 0; r < 16; r++) begin
            drive(1'b1, tbl[r].nin, tbl[r].din);
            chk($sformatf("tbl%0d q_push_valid", r), {63'd0, q_push_valid}, {63'd0, tbl[r].pv});
            chk($sformatf("tbl%0d q_pop_valid", r), {63'd0, q_pop_valid}, {63'd0, tbl[r].popv});
            chk($sformatf("tbl%0d aktv", r), {60'd0, aktv_v}, {60'd0, tbl[r].aktv});
            for (int k = 0; k < 4; k++)
                chk($sformatf("tbl%0d out%0d", r, k), outv(k), tbl[r].v[k]);
        end
        chk("wrap out0", bus.output_0, 64'h8000_0000_0000_0000);
        chk("wrap out3", bus.output_3, 64'h8000_0000_0000_0003);

        // Back-to-back: 3 and 4 strobed two cycles apart.
        pushes = 0;
        pops   = 0;
        for (int c = 0; c < 14; c++) begin
            drive(1'b1, (c == 0 || c == 2), (c == 0) ? 64'd3 : 64'd4);
            if (q_push_valid) pushes++;
            if (q_pop_valid) pops++;
            if (aktv_v[0]) begin o0v.push_back(bus.output_0); o0c.push_back(c); end
            if (aktv_v[3]) begin o3v.push_back(bus.output_3); o3c.push_back(c); end
        end
        chk("b2b pushes", 64'(pushes), 64'd2);
        chk("b2b pops", 64'(pops), 64'd2);
        chk("b2b out0 pulses", 64'(o0v.size()), 64'd2);
        chk("b2b out3 pulses", 64'(o3v.size()), 64'd2);
        if (o0v.size() == 2 && o3v.size() == 2) begin
            chk("b2b out0 first", o0v[0], 64'd4);
            chk("b2b out0 second", o0v[1], 64'd5);
            chk("b2b out3 first", o3v[0], 64'd7);
            chk("b2b out3 second", o3v[1], 64'd8);
            chk("b2b out0 first cycle", 64'(o0c[0]), 64'd3);
            chk("b2b wave spacing", 64'(o0c[1] - o0c[0]), 64'd2);
            chk("b2b out3 first cycle", 64'(o3c[0]), 64'd6);
            chk("b2b out3 spacing", 64'(o3c[1] - o3c[0]), 64'd2);
        end

        // en=0 for three cycles while an event sits in S0.
        drive(1'b1, 1'b1, 64'd20);
        drive(1'b1, 1'b0, 64'd0);
        for (int s = 0; s < 3; s++) begin
            drive(1'b0, 1'b1, 64'd77);
            chk($sformatf("stall%0d aktv", s), {60'd0, aktv_v}, 64'd0);
            chk($sformatf("stall%0d out0 held", s), bus.output_0, 64'd5);
            chk($sformatf("stall%0d q_push/pop", s), {62'd0, q_push, q_pop}, 64'd0);
        end
        drive(1'b1, 1'b0, 64'd0);
        chk("stall resume enable_out0", {63'd0, enable_out0}, 64'd1);
        chk("stall resume aktv", {60'd0, aktv_v}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 64'd0);
            chk($sformatf("stall wave aktv%0d", k), {60'd0, aktv_v}, 64'(1 << k));
            chk($sformatf("stall wave out%0d", k), outv(k), 64'(21 + k));
        end

        // Reset one cycle after strobing 13.
        drive(1'b1, 1'b1, 64'd13);
        drive(1'b1, 1'b0, 64'd0);
        reset_pulse("midreset");
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 1'b0, 64'd0);
            chk($sformatf("postreset%0d aktv", c), {60'd0, aktv_v}, 64'd0);
            chk($sformatf("postreset%0d q_pop_valid", c), {63'd0, q_pop_valid}, 64'd0);
        end
        drive(1'b1, 1'b1, 64'd14);
        for (int c = 1; c <= 6; c++) begin
            drive(1'b1, 1'b0, 64'd0);
            if (c == 3) chk("after reset out0", bus.output_0, 64'd15);
            if (c == 6) begin
                chk("after reset aktv3", {60'd0, aktv_v}, 64'b1000);
                chk("after reset out3", bus.output_3, 64'd18);
            end
        end

        // Queue full: block pops, fill, then push while full with a pop happening.
        drive(1'b1, 1'b0, 64'd0);
        drive(1'b1, 1'b0, 64'd0);
        force dut.q_pop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 64'(10 + i));
            chk($sformatf("fill%0d q_push_valid", i), {63'd0, q_push_valid}, 64'd1);
            chk($sformatf("fill%0d q_pop_valid", i), {63'd0, q_pop_valid}, 64'd0);
        end
        @(negedge clk);
        release dut.q_pop;
        en              = 1'b1;
        bus.new_input_0 = 1'b1;
        bus.input_0     = 64'd99;
        #1;
        chk("full push dropped", {63'd0, q_push_valid}, 64'd0);
        chk("full pop performed", {63'd0, q_pop_valid}, 64'd1);
        o0v.delete();
        for (int c = 0; c < 12; c++) begin
            drive(1'b1, 1'b0, 64'd0);
            if (aktv_v[0]) o0v.push_back(bus.output_0);
        end
        chk("full drain count", 64'(o0v.size()), 64'd4);
        for (int i = 0; i < 4 && i < o0v.size(); i++)
            chk($sformatf("full drain order%0d", i), o0v[i], 64'(11 + i));
        chk("full drained empty", {63'd0, q_pop}, 64'd0);

        // Randomized traffic against the model.
        reset_pulse("randreset");
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic e, n, e_pushv, e_pop, e_s0;
            logic [63:0] d;
            if ($urandom_range(99) == 0) begin
                reset_pulse($sformatf("rnd%0d reset", cyc));
                model_reset();
                continue;
            end
            e = ($urandom_range(9) != 0);
            n = $urandom_range(1) == 1;
            d = {$urandom, $urandom};
            if ($urandom_range(7) == 0) d = {1'b0, {63{1'b1}}};
            drive(e, n, d);
            e_pushv = n && e && (mq.size() < int'(DEPTH));
            e_pop   = e && (mq.size() > 0);
            e_s0    = 1'b0;
            foreach (fa[i]) if (fa[i] == 1) e_s0 = 1'b1;
            chk($sformatf("rnd%0d q_push", cyc), {63'd0, q_push}, {63'd0, n & e});
            chk($sformatf("rnd%0d q_push_valid", cyc), {63'd0, q_push_valid}, {63'd0, e_pushv});
            chk($sformatf("rnd%0d q_pop_valid", cyc), {62'd0, q_pop, q_pop_valid},
                {62'd0, e_pop, e_pop});
            chk($sformatf("rnd%0d enable_in0", cyc), {63'd0, enable_in0}, {63'd0, e_pop});
            chk($sformatf("rnd%0d enables", cyc), {60'd0, en_v},
                {60'd0, m_aktv[2:0], e_s0});
            chk($sformatf("rnd%0d aktv", cyc), {60'd0, aktv_v}, {60'd0, m_aktv});
            for (int k = 0; k < 4; k++)
                chk($sformatf("rnd%0d out%0d", cyc, k), outv(k), m_out[k]);
            if (e) begin
                m_aktv = '0;
                for (int i = fa.size() - 1; i >= 0; i--) begin
                    fa[i]++;
                    if (fa[i] >= 2) begin
                        m_out[fa[i]-2]  = fv[i] + 64'(fa[i] - 1);
                        m_aktv[fa[i]-2] = 1'b1;
                    end
                    if (fa[i] == 5) begin
                        fa.delete(i);
                        fv.delete(i);
                    end
                end
                if (e_pop) begin
                    fv.push_back(mq.pop_front());
                    fa.push_back(1);
                end
                if (e_pushv) mq.push_back(d);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
